// File: rtl/dbr_pkg.sv
// Shared types and constants for data_bus_resizer: FSM states, memory-width
// encodings and the lane-group masks used to split an access into beats.
package dbr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        DW_8,
        DW_16,
        DW_32
    } dw_e;

    localparam logic [5:0] DW_ENC_8  = 6'd8;
    localparam logic [5:0] DW_ENC_16 = 6'd16;
    localparam logic [5:0] DW_ENC_32 = 6'd32;

    localparam logic [3:0] GRP_W32    = 4'b1111;
    localparam logic [3:0] GRP_W16_LO = 4'b0011;
    localparam logic [3:0] GRP_W16_HI = 4'b1100;
    localparam logic [3:0] GRP_W8_L0  = 4'b0001;

    // Unsupported width codes fall back to a full 32-bit memory.
    function automatic dw_e dw_decode(input logic [5:0] dw);
        case (dw)
            DW_ENC_8:  return DW_8;
            DW_ENC_16: return DW_16;
            default:   return DW_32;
        endcase
    endfunction

    // Lanes covered by group g at width w; groups beyond the last one are empty.
    function automatic logic [3:0] group_mask(input dw_e w, input logic [1:0] g);
        logic [3:0] m;
        m = 4'b0000;
        case (w)
            DW_8:    m = GRP_W8_L0 << g;
            DW_16: begin
                if (g == 2'd0)      m = GRP_W16_LO;
                else if (g == 2'd1) m = GRP_W16_HI;
            end
            default: if (g == 2'd0) m = GRP_W32;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/dbr_beat_planner.sv
// Combinational beat planner: for beat number beat_idx of an access, returns
// the enabled lanes serviced by that beat and whether it is the final beat.
module dbr_beat_planner
    import dbr_pkg::*;
(
    input  logic [3:0] ben,
    input  logic [5:0] dw,
    input  logic [1:0] beat_idx,
    output logic [3:0] lane_mask,
    output logic       last
);

    logic [3:0] en;
    dw_e        width;

    assign en    = ~ben;
    assign width = dw_decode(dw);

    // Beat k is the k-th group, in ascending lane order, that has an enabled lane.
    always_comb begin
        logic [2:0] n_active;
        logic [3:0] gm;
        lane_mask = 4'b0000;
        n_active  = 3'd0;
        gm        = 4'b0000;
        for (int g = 0; g < 4; g++) begin
            gm = group_mask(width, 2'(g)) & en;
            if (gm != 4'b0000) begin
                if (n_active == {1'b0, beat_idx}) lane_mask = gm;
                n_active = n_active + 3'd1;
            end
        end
        last = (n_active == {1'b0, beat_idx} + 3'd1);
    end

endmodule

// File: rtl/data_bus_resizer.sv
// Adapts a 32-bit controller access to an 8/16/32-bit memory by issuing one
// wait-stated beat per enabled lane group. Define DBR_SZRQ_EN to use sizing requests.
module data_bus_resizer
    import dbr_pkg::*;
#(
    parameter int WS_W = 4
) (
    input  logic            CLK,
    input  logic            RESn,
    input  logic            CE,
    input  logic [WS_W-1:0] WS,
    input  logic [5:0]      DW,
    input  logic            CTLR_DAn,
    input  logic [3:0]      CTLR_BEn,
    output logic            CTLR_READYn,
    output logic            CTLR_SZRQn,
    output logic [31:0]     CTLR_DI,
    input  logic [31:0]     CTLR_DO,
    output logic            MEM_nCE,
    output logic [31:0]     MEM_DI,
    input  logic [31:0]     MEM_DO
);

    state_e          state;
    state_e          state_nxt;
    logic [3:0]      ben_q;
    logic [5:0]      dw_q;
    logic [WS_W-1:0] ws_q;
    logic [WS_W-1:0] wait_cnt;
    logic [1:0]      beat_cnt;
    logic [31:0]     hold;
    logic [3:0]      lane_mask;
    logic            plan_last;
    logic            last_beat;
    logic            accept;
    logic            beat_end;

    dbr_beat_planner u_planner (
        .ben      (ben_q),
        .dw       (dw_q),
        .beat_idx (beat_cnt),
        .lane_mask(lane_mask),
        .last     (plan_last)
    );

    assign accept   = (state == ST_IDLE) && !CTLR_DAn;
    assign beat_end = (state == ST_BEAT) && (wait_cnt == ws_q);

`ifdef DBR_SZRQ_EN
    logic split_q;
    logic split_req;

    // A 16-bit access stops after its lowest halfword; the controller reissues the upper half.
    assign split_req = (dw_decode(DW) == DW_16) && (CTLR_BEn[1:0] != 2'b11)
                       && (CTLR_BEn[3:2] != 2'b11);
    assign last_beat = plan_last || (dw_decode(dw_q) == DW_16);

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn)            split_q <= 1'b0;
        else if (CE && accept) split_q <= split_req;
    end
`else
    assign last_beat = plan_last;
`endif

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn)   state <= ST_IDLE;
        else if (CE) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!CTLR_DAn) state_nxt = (CTLR_BEn == 4'b1111) ? ST_DONE : ST_BEAT;
            ST_BEAT: if (beat_end && last_beat) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The beat plan and wait count are latched at acceptance; later input changes are ignored.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            ben_q    <= 4'b1111;
            dw_q     <= DW_ENC_32;
            ws_q     <= '0;
            wait_cnt <= '0;
            beat_cnt <= 2'd0;
            hold     <= 32'h0;
        end else if (CE) begin
            if (accept) begin
                ben_q    <= CTLR_BEn;
                dw_q     <= DW;
                ws_q     <= WS;
                wait_cnt <= '0;
                beat_cnt <= 2'd0;
                hold     <= 32'h0;
            end else if (state == ST_BEAT) begin
                if (beat_end) begin
                    hold     <= hold | (MEM_DO & lane_expand(lane_mask));
                    wait_cnt <= '0;
                    beat_cnt <= beat_cnt + 2'd1;
                end else begin
                    wait_cnt <= wait_cnt + WS_W'(1);
                end
            end
        end
    end

    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        MEM_nCE     = 1'b1;
        CTLR_READYn = 1'b1;
        CTLR_SZRQn  = 1'b1;
        case (state)
            ST_BEAT: MEM_nCE = 1'b0;
            ST_DONE: begin
                CTLR_READYn = 1'b0;
`ifdef DBR_SZRQ_EN
                CTLR_SZRQn  = !split_q;
`endif
            end
            default: ;
        endcase
    end

    assign CTLR_DI = hold;
    assign MEM_DI  = CTLR_DO;

endmodule

// File: tb/tb_data_bus_resizer.sv
// Self-checking bench for data_bus_resizer: directed accesses with hand-computed
// expectations, then randomized traffic checked every cycle against a cycle-schedule model.
module tb_data_bus_resizer;

    logic        CLK = 1'b0;
    logic        RESn;
    logic        CE;
    logic [3:0]  WS;
    logic [5:0]  DW;
    logic        CTLR_DAn;
    logic [3:0]  CTLR_BEn;
    logic        CTLR_READYn;
    logic        CTLR_SZRQn;
    logic [31:0] CTLR_DI;
    logic [31:0] CTLR_DO;
    logic        MEM_nCE;
    logic [31:0] MEM_DI;
    logic [31:0] MEM_DO;

    data_bus_resizer #(.WS_W(4)) dut (
        .CLK        (CLK),
        .RESn       (RESn),
        .CE         (CE),
        .WS         (WS),
        .DW         (DW),
        .CTLR_DAn   (CTLR_DAn),
        .CTLR_BEn   (CTLR_BEn),
        .CTLR_READYn(CTLR_READYn),
        .CTLR_SZRQn (CTLR_SZRQn),
        .CTLR_DI    (CTLR_DI),
        .CTLR_DO    (CTLR_DO),
        .MEM_nCE    (MEM_nCE),
        .MEM_DI     (MEM_DI),
        .MEM_DO     (MEM_DO)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: one schedule entry per CE cycle ----------------
    typedef struct packed {
        logic       nce;
        logic       readyn;
        logic       szrqn;
        logic [3:0] cap;
    } cyc_t;

    cyc_t        sched[$];
    logic [31:0] exp_di = 32'h0;
    cyc_t        idle_cyc;

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) if (m[i]) r = r | (32'hFF << (8 * i));
        return r;
    endfunction

    task automatic plan_access(input logic [3:0] ben, input logic [5:0] dw, input int ws);
        logic [3:0] en;
        logic [3:0] m;
        logic [3:0] groups[$];
        int         lanes_per;
        bit         split;
        cyc_t       c;
        en        = ~ben;
        lanes_per = (dw == 6'd8) ? 1 : (dw == 6'd16) ? 2 : 4;
        for (int g = 0; g < 4 / lanes_per; g++) begin
            m = 4'(((1 << lanes_per) - 1) << (g * lanes_per)) & en;
            if (m != 4'b0000) groups.push_back(m);
        end
        split = 1'b0;
`ifdef DBR_SZRQ_EN
        if (lanes_per == 2 && groups.size() == 2) begin
            split = 1'b1;
            groups.delete(1);
        end
`endif
        foreach (groups[i]) begin
            for (int w = 0; w <= ws; w++) begin
                c = '{nce: 1'b0, readyn: 1'b1, szrqn: 1'b1, cap: (w == ws) ? groups[i] : 4'b0000};
                sched.push_back(c);
            end
        end
        c = '{nce: 1'b1, readyn: 1'b0, szrqn: !split, cap: 4'b0000};
        sched.push_back(c);
    endtask

    always @(posedge CLK) begin
        if (!RESn) begin
            sched.delete();
            exp_di = 32'h0;
        end else if (CE) begin
            if (sched.size() != 0) begin
                if (sched[0].cap != 4'b0000) exp_di = exp_di | (MEM_DO & expand(sched[0].cap));
                void'(sched.pop_front());
            end else if (!CTLR_DAn) begin
                exp_di = 32'h0;
                plan_access(CTLR_BEn, DW, int'(WS));
            end
        end
    end

    // Compare process: control outputs every cycle, read data while READYn is expected low.
    always @(posedge CLK) begin
        cyc_t e;
        #1;
        e = (sched.size() != 0) ? sched[0] : idle_cyc;
        check("ctrl_outputs", {61'h0, MEM_nCE, CTLR_READYn, CTLR_SZRQn},
              {61'h0, e.nce, e.readyn, e.szrqn});
        if (!e.readyn) check("done_data", 64'(CTLR_DI), 64'(exp_di));
        check("mem_di", 64'(MEM_DI), 64'(CTLR_DO));
    end

    // ---------------- directed access with literal expectations ----------------
    task automatic directed(input string name, input logic [5:0] dw, input logic [3:0] ws,
                            input logic [3:0] ben, input logic [31:0] mdo, input bit ce_toggle,
                            input int exp_lat, input int exp_nce, input logic [31:0] exp_data,
                            input logic exp_szrq);
        int lat;
        int nce_cnt;
        bit ce_now;
        @(negedge CLK);
        CTLR_DAn = 1'b1; CE = 1'b1; DW = dw; WS = ws; CTLR_BEn = ben; MEM_DO = mdo;
        repeat (3) @(negedge CLK);
        CTLR_DAn = 1'b0;
        @(posedge CLK); #1;
        lat     = 1;
        nce_cnt = (MEM_nCE == 1'b0) ? 1 : 0;
        while (CTLR_READYn !== 1'b0 && lat < 200) begin
            @(negedge CLK);
            CTLR_DAn = 1'b1;
            ce_now   = ce_toggle ? !CE : 1'b1;
            CE       = ce_now;
            @(posedge CLK); #1;
            if (ce_now) begin
                lat++;
                if (MEM_nCE == 1'b0) nce_cnt++;
            end
        end
        check($sformatf("%s latency", name), 64'(lat), 64'(exp_lat));
        check($sformatf("%s nce_cycles", name), 64'(nce_cnt), 64'(exp_nce));
        check($sformatf("%s data", name), 64'(CTLR_DI), 64'(exp_data));
        check($sformatf("%s szrqn", name), 64'(CTLR_SZRQn), 64'(exp_szrq));
        @(negedge CLK);
        CE = 1'b1;
    endtask

    initial begin
        int ready_lows;
        idle_cyc = '{nce: 1'b1, readyn: 1'b1, szrqn: 1'b1, cap: 4'b0000};
        RESn = 1'b0; CE = 1'b1; WS = 4'd0; DW = 6'd32; CTLR_DAn = 1'b1;
        CTLR_BEn = 4'b1111; CTLR_DO = 32'h0; MEM_DO = 32'h0;
        repeat (2) @(negedge CLK);
        check("reset nce", 64'(MEM_nCE), 64'(1'b1));
        check("reset readyn", 64'(CTLR_READYn), 64'(1'b1));
        check("reset szrqn", 64'(CTLR_SZRQn), 64'(1'b1));
        check("reset data", 64'(CTLR_DI), 64'h0);
        RESn = 1'b1;

        directed("w32_ws0", 6'd32, 4'd0, 4'b0000, 32'h12345678, 1'b0, 2, 1, 32'h12345678, 1'b1);
`ifdef DBR_SZRQ_EN
        directed("w16_ws2", 6'd16, 4'd2, 4'b0000, 32'hCAFEF00D, 1'b0, 4, 3, 32'h0000F00D, 1'b0);
        directed("w16_ce_toggle", 6'd16, 4'd1, 4'b0000, 32'h55AA33CC, 1'b1, 3, 2, 32'h000033CC, 1'b0);
`else
        directed("w16_ws2", 6'd16, 4'd2, 4'b0000, 32'hCAFEF00D, 1'b0, 7, 6, 32'hCAFEF00D, 1'b1);
        directed("w16_ce_toggle", 6'd16, 4'd1, 4'b0000, 32'h55AA33CC, 1'b1, 5, 4, 32'h55AA33CC, 1'b1);
`endif
        directed("w8_one_lane", 6'd8, 4'd0, 4'b1101, 32'hAABBCCDD, 1'b0, 2, 1, 32'h0000CC00, 1'b1);
        directed("no_lanes", 6'd32, 4'd3, 4'b1111, 32'hFFFFFFFF, 1'b0, 1, 0, 32'h0, 1'b1);
        directed("dw_odd_as_32", 6'd7, 4'd0, 4'b0000, 32'h0BADBEEF, 1'b0, 2, 1, 32'h0BADBEEF, 1'b1);
        directed("w16_low_only", 6'd16, 4'd0, 4'b1100, 32'hDEADBEEF, 1'b0, 2, 1, 32'h0000BEEF, 1'b1);
        directed("w8_lanes_0_3", 6'd8, 4'd1, 4'b0110, 32'h11223344, 1'b0, 5, 4, 32'h11000044, 1'b1);

        // Randomized traffic; WS changes only while the model says the resizer is idle.
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            CE       = ($urandom_range(0, 3) != 0);
            CTLR_DAn = ($urandom_range(0, 9) < 3);
            CTLR_BEn = ($urandom_range(0, 7) == 0) ? 4'b1111 : 4'($urandom);
            case ($urandom_range(0, 3))
                0:       DW = 6'd8;
                1:       DW = 6'd16;
                2:       DW = 6'd32;
                default: DW = 6'($urandom);
            endcase
            if (sched.size() == 0)
                WS = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            MEM_DO  = $urandom;
            CTLR_DO = $urandom;
        end
        CTLR_DAn = 1'b1; CE = 1'b1;
        repeat (80) @(negedge CLK);

        // Reset in the middle of a beat: immediate reset values, then no READYn pulse.
        DW = 6'd8; WS = 4'd5; CTLR_BEn = 4'b0000; MEM_DO = 32'hFFFFFFFF; CTLR_DAn = 1'b0;
        @(negedge CLK);
        CTLR_DAn = 1'b1;
        repeat (8) @(negedge CLK);
        check("pre_reset nce", 64'(MEM_nCE), 64'(1'b0));
        check("pre_reset data", 64'(CTLR_DI), 64'h000000FF);
        #2 RESn = 1'b0;
        #1;
        check("async_reset nce", 64'(MEM_nCE), 64'(1'b1));
        check("async_reset readyn", 64'(CTLR_READYn), 64'(1'b1));
        check("async_reset szrqn", 64'(CTLR_SZRQn), 64'(1'b1));
        check("async_reset data", 64'(CTLR_DI), 64'h0);
        repeat (2) @(negedge CLK);
        RESn = 1'b1;
        ready_lows = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (CTLR_READYn == 1'b0) ready_lows++;
        end
        check("no_ready_after_abort", 64'(ready_lows), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_bus_resizer.md
DATA_BUS_RESIZER -- requirements
Module: data_bus_resizer

Interface
REQ-001 SHALL have parameter WS_W, default 4: width of the WS port.
REQ-002 SHALL have port CLK, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port RESn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port CE, input, 1: clock enable; state advances only on edges with CE=1.
REQ-005 SHALL have port WS, input, WS_W: wait states per memory beat (0..15).
REQ-006 SHALL have port DW, input, 6: native memory width in bits (8, 16, 32); any other value is treated as 32.
REQ-007 SHALL have port CTLR_DAn, input, 1: controller data-access strobe, active-low.
REQ-008 SHALL have port CTLR_BEn, input, 4: byte enables, active-low, lane i = bits 8i+7:8i.
REQ-009 SHALL have port CTLR_READYn, output, 1: access complete, active-low.
REQ-010 SHALL have port CTLR_SZRQn, output, 1: bus-sizing request, active-low.
REQ-011 SHALL have port CTLR_DI, output, 32: read data to controller.
REQ-012 SHALL have port CTLR_DO, input, 32: write data from controller.
REQ-013 SHALL have port MEM_nCE, output, 1: memory chip enable, active-low.
REQ-014 SHALL have port MEM_DI, output, 32: write data to memory, lane-aligned, equal to CTLR_DO combinationally.
REQ-015 SHALL have port MEM_DO, input, 32: lane-aligned memory read data.

Function
REQ-016 SHALL implement states IDLE, BEAT, DONE.
REQ-017 IDLE: on a CE edge with CTLR_DAn=0, SHALL clear the holding register, compute beats, and go to BEAT, or go to DONE if CTLR_BEn=4'b1111.
REQ-018 Beat planning: lanes are grouped by DW (DW=32: one group {3:0}; DW=16: {1:0},{3:2}; DW=8: one per lane); one beat SHALL be issued per group containing at least one enabled lane, in ascending lane order.
REQ-019 BEAT SHALL hold MEM_nCE=0 for WS+1 CE cycles per beat, with MEM_nCE continuously low across consecutive beats.
REQ-020 SHALL capture MEM_DO lanes of the current group that are enabled into the holding register on the last cycle of each beat.
REQ-021 After the last beat, SHALL enter DONE with MEM_nCE=1.
REQ-022 DONE SHALL last one CE cycle, with CTLR_READYn=0 and CTLR_DI equal to the holding register; next state is IDLE.
REQ-023 Disabled lanes of CTLR_DI SHALL read 0.
REQ-024 Latency from the accepting edge to CTLR_READYn=0 SHALL be 1 + beats*(WS+1) CE cycles, where an all-disabled CTLR_BEn gives 1.
REQ-025 IDLE SHALL accept a new access on the edge immediately after DONE if CTLR_DAn=0; accesses may be back-to-back.
REQ-026 CTLR_BEn and CTLR_DAn changes during BEAT SHALL be ignored; the beat plan is latched at acceptance.
REQ-027 With CE=0, all registers and outputs SHALL hold.
REQ-028 Outside DONE, CTLR_READYn SHALL be 1; outside BEAT, MEM_nCE SHALL be 1.

Reset
REQ-029 RESn=0 SHALL immediately force: state IDLE, CTLR_READYn=1, CTLR_SZRQn=1, MEM_nCE=1, CTLR_DI=0, beat and wait counters 0.
REQ-030 Reset during BEAT SHALL abort the access with no READYn pulse.

Configuration
REQ-031 DBR_SZRQ_EN defined and DW=16: SHALL perform only the lowest enabled halfword beat and, if both halves are enabled, assert CTLR_SZRQn=0 together with CTLR_READYn=0 in DONE so the controller reissues the upper half.
REQ-032 DBR_SZRQ_EN undefined: CTLR_SZRQn SHALL be constant 1 and all splitting SHALL be internal per REQ-018.

Structure
REQ-033 Package dbr_pkg SHALL hold the state enum, DW encodings (8/16/32), and lane-group mask constants.
REQ-034 Combinational sub-module dbr_beat_planner (inputs BEn, DW, beat index; outputs lane mask, last flag) SHALL implement beat planning.

Verification
REQ-035 DW=32, WS=0, BEn=0000, MEM_DO=32'h12345678 -> MEM_nCE low 1 cycle, READYn low 2 cycles after accept, CTLR_DI=32'h12345678.
REQ-036 DW=16, WS=2, BEn=0000 -> two beats of 3 cycles each, READYn at cycle 7, both halves captured.
REQ-037 DW=8, WS=0, BEn=1101, MEM_DO=32'hAABBCCDD -> one beat, CTLR_DI=32'h0000CC00.
REQ-038 BEn=1111, DAn=0 -> MEM_nCE stays 1, READYn low 1 cycle after accept.
REQ-039 CE toggled 1/0 during DW=16, WS=1 -> cycle counts are in CE-high edges only; reset asserted mid-BEAT -> all outputs take reset values immediately and no READYn pulse occurs.
REQ-040 DBR_SZRQ_EN, DW=16, BEn=0000 -> one beat, READYn=0 and SZRQn=0 together, CTLR_DI[31:16]=0.
